// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the byte-serial carry-lookahead adder/subtractor:
//   - state_e   : controller states (IDLE, RUN, DONE)
//   - SLICE_W   : width of the single arithmetic slice (one byte)
//   - idx_width : width of the byte-index counter for a given slice count
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 8;

    // Width of a counter able to address nb byte slices (never narrower than 1).
    function automatic int idx_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/addsub_slice8.sv
// -----------------------------------------------------------------------------
// addsub_slice8
// Purely combinational 8-bit carry-lookahead adder built from two 4-bit
// lookahead groups. The upper group's carry-in comes from the lower group's
// generate/propagate, not from a ripple through its bits.
// Ports:
//   a_i, b_i  [7:0]  addends
//   cin_i            carry in
//   s_o       [7:0]  sum
//   cout_o           carry out of bit 7
// -----------------------------------------------------------------------------
module addsub_slice8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] s_o,
    output logic       cout_o
);

    logic [7:0] g_s;
    logic [7:0] p_s;
    logic [7:0] c_s;
    logic       gg0_s;
    logic       pg0_s;
    logic       gg1_s;
    logic       pg1_s;
    logic       c4_s;

    // Bit generate/propagate, both groups' lookahead carries and the sum.
    always_comb begin
        g_s = a_i & b_i;
        p_s = a_i ^ b_i;

        // Lower group: carries 0..3 and group generate/propagate.
        c_s[0] = cin_i;
        c_s[1] = g_s[0] | (p_s[0] & cin_i);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin_i);
        gg0_s  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        pg0_s  = &p_s[3:0];

        // Group-level lookahead into the upper group.
        c4_s   = gg0_s | (pg0_s & cin_i);

        // Upper group: carries 4..7 and group generate/propagate.
        c_s[4] = c4_s;
        c_s[5] = g_s[4] | (p_s[4] & c4_s);
        c_s[6] = g_s[5] | (p_s[5] & g_s[4]) | (p_s[5] & p_s[4] & c4_s);
        c_s[7] = g_s[6] | (p_s[6] & g_s[5]) | (p_s[6] & p_s[5] & g_s[4])
               | (p_s[6] & p_s[5] & p_s[4] & c4_s);
        gg1_s  = g_s[7] | (p_s[7] & g_s[6]) | (p_s[7] & p_s[6] & g_s[5])
               | (p_s[7] & p_s[6] & p_s[5] & g_s[4]);
        pg1_s  = &p_s[7:4];

        cout_o = gg1_s | (pg1_s & c4_s);
        s_o    = p_s ^ c_s;
    end

endmodule

// File: rtl/serial_cla_addsub.sv
// -----------------------------------------------------------------------------
// serial_cla_addsub
// Multi-cycle WIDTH-bit adder/subtractor. Operands are captured on the input
// handshake and processed one byte per cycle (LSB byte first) through a single
// 8-bit CLA slice, with the inter-byte carry held in a register.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry seeds to 1.
// Optional build macro ADDSUB_FLAGS_EN adds the zero and ovf outputs.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  request handshake (ready only in IDLE, low in reset)
//   a, b, sub            operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready  result handshake (valid throughout DONE)
//   result, carry_out    sum/difference mod 2^WIDTH, final carry (1 = no borrow)
//   zero, ovf            result==0, signed overflow (ADDSUB_FLAGS_EN only)
// -----------------------------------------------------------------------------
module serial_cla_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NB = WIDTH / SLICE_W;
    localparam int IW = idx_width(NB);

    state_e           state_q,  state_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
`ifdef ADDSUB_FLAGS_EN
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
`endif

    logic [7:0]       slice_a_s;
    logic [7:0]       slice_b_s;
    logic [7:0]       slice_s_s;
    logic             slice_cout_s;

    // Current byte of each operand; {idx,3'b000} is the bit offset of byte idx.
    always_comb begin
        slice_a_s = a_q[{idx_q, 3'b000} +: SLICE_W];
        slice_b_s = b_q[{idx_q, 3'b000} +: SLICE_W];
    end

    addsub_slice8 u_slice (
        .a_i    (slice_a_s),
        .b_i    (slice_b_s),
        .cin_i  (carry_q),
        .s_o    (slice_s_s),
        .cout_o (slice_cout_s)
    );

    // Controller next-state and datapath next-value logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ADDSUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = {IW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[{idx_q, 3'b000} +: SLICE_W] = slice_s_s;
                carry_d = slice_cout_s;
                if (idx_q == IW'(NB - 1)) begin
                    state_d = DONE;
                    cout_d  = slice_cout_s;
`ifdef ADDSUB_FLAGS_EN
                    // Flags see the complete result including the byte written now.
                    zero_d  = (result_d == {WIDTH{1'b0}});
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (result_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= {IW{1'b0}};
            carry_q  <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Outputs decode directly from registered state; in_ready is also held low in reset.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        result    = result_q;
        carry_out = cout_q;
`ifdef ADDSUB_FLAGS_EN
        zero      = zero_q;
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_cla_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_cla_addsub
// Directed self-checking bench for serial_cla_addsub (WIDTH=32). Expected
// values are hand-computed constants. Inputs change and outputs are sampled on
// the falling clock edge. Flag checks are included when ADDSUB_FLAGS_EN is set.
// -----------------------------------------------------------------------------
module tb_serial_cla_addsub;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
`ifdef ADDSUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_cla_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
`ifdef ADDSUB_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, wait for the result with out_ready high, check it
    // and the handshake timing around it.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic op_sub, input logic [31:0] exp_res, input logic exp_co,
                          input logic exp_z, input logic exp_v);
        int lat;
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        sub       = op_sub;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd5);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " carry_out"}, 64'(carry_out), 64'(exp_co));
`ifdef ADDSUB_FLAGS_EN
        check({tag, " zero"}, 64'(zero), 64'(exp_z));
        check({tag, " ovf"}, 64'(ovf), 64'(exp_v));
`else
        if (exp_z !== exp_v) begin
            // flags are not built in this configuration
        end
`endif
        @(negedge clk);
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        sub       = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset carry_out", 64'(carry_out), 64'd0);
`ifdef ADDSUB_FLAGS_EN
        check("reset zero", 64'(zero), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_op("add ff+1",      32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_op("add ffffffff+1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("sub 7-5",       32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op("sub 5-7",       32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("add ovf",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run_op("sub ovf",       32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold the result for 10 cycles while a new request is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 32'hA5A5_A5A5;
        b         = 32'h5A5A_5A5A;
        sub       = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int lat;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("bp latency", 64'(lat), 64'd5);
        end
        in_valid = 1'b1;
        a        = 32'h0000_0001;
        b        = 32'h0000_0001;
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp result", 64'(result), 64'hFFFF_FFFF);
            check("bp carry_out", 64'(carry_out), 64'd0);
            check("bp in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp released out_valid", 64'(out_valid), 64'd0);
        check("bp ignored request", 64'(in_ready), 64'd1);
        run_op("after bp sub", 32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);

        // Reset during the second RUN cycle discards the partial operation.
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;
        sub      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-run rst out_valid", 64'(out_valid), 64'd0);
        check("mid-run rst result", 64'(result), 64'd0);
        check("mid-run rst carry_out", 64'(carry_out), 64'd0);
        check("mid-run rst in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("after rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("after rst still idle", 64'(out_valid), 64'd0);
        run_op("add 1+2", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        run_op("add full", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_cla_addsub.md
Name: serial_cla_addsub

Overview:
- Multi-cycle wide adder/subtractor with a valid/ready handshake.
- Processes WIDTH-bit operands one byte per cycle, LSB byte first, through a single 8-bit carry-lookahead slice.
- Holds the carry between cycles in a register.
- Sits upstream of accumulator/ALU consumers. Trades latency for area versus a full-width CLA.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 8 and ≥16.
- NB, WIDTH/8, number of byte slices (derived localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum or difference (mod 2^WIDTH).
- carry_out  out  1  final carry. For sub, 1 = no borrow (A≥B unsigned).
- zero  out  1  result==0 (only when ADDSUB_FLAGS_EN is defined).
- ovf  out  1  signed overflow (only when ADDSUB_FLAGS_EN is defined).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - State IDLE, byte index 0, carry register 0.
  - result 0, carry_out 0, out_valid 0, zero 0, ovf 0.
  - in_ready is 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a and b_eff = sub ? ~b : b, and set carry register = sub.
  - idx <= 0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice idx computes a[8i+7:8i] + b_eff[8i+7:8i] + carry.
  - Writes result byte idx and sets carry <= slice cout.
  - idx increments. When idx==NB-1, go to DONE after this edge with carry_out = final cout.
- DONE:
  - out_valid=1, in_ready=0.
  - result, carry_out and flags are held stable until out_valid&out_ready, then go to IDLE.
  - in_valid is ignored in DONE and RUN. There is no overlap and no accept on the same cycle as the output handshake.
- Latency:
  - Accept in cycle 0; RUN occupies cycles 1..NB; out_valid is first high in cycle NB+1.
  - For WIDTH=32, out_valid is first high in cycle 5.
  - Throughput is one operation per NB+2 cycles minimum.
- Arithmetic: unsigned mod 2^WIDTH. Subtraction is A + ~B + 1 (two's complement).
- Carry on entry to byte 0: 0 for add, 1 for sub. Byte indices never wrap mid-operation.
- Reset asserted in any state, including mid-RUN: the next edge returns to IDLE with all outputs at reset values. The partial result is discarded.
- result bytes not yet written during RUN are don't-care. They are visible only in DONE.

Optional Feature:
- Macro ADDSUB_FLAGS_EN.
- Defined:
  - zero and ovf ports exist and are registered on the transition into DONE.
  - zero = (result==0).
  - ovf = (a[MSB]==b_eff[MSB]) && (result[MSB]!=a[MSB]).
  - Both are 0 at reset and held through DONE.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package addsub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SLICE_W=8 constant;
  - function computing the index width $clog2(NB).
- One sub-module, addsub_slice8: purely combinational 8-bit CLA (a, b, cin -> s, cout) built from two 4-bit lookahead groups. It is instantiated once in serial_cla_addsub.

Test Plan (WIDTH=32):
- Add 0x000000FF+0x00000001 with out_ready=1 -> result 0x00000100, carry_out 0. out_valid first high exactly 5 cycles after accept, for one cycle. in_ready returns the next cycle.
- Add 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry_out 1. With flags: zero=1, ovf=0.
- Sub 7−5 -> 0x00000002, carry_out 1. Sub 5−7 -> 0xFFFFFFFE, carry_out 0 (borrow).
- Flags on: add 0x7FFFFFFF+1 -> 0x80000000, ovf=1, zero=0. Sub 0x80000000−1 -> 0x7FFFFFFF, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE.
  - result and carry_out stay stable, in_ready=0.
  - A new in_valid is ignored.
  - After out_ready=1, the next request is accepted and computes correctly.
- Reset pulse during RUN cycle 2 of 0x12345678+0x11111111:
  - next cycle: state IDLE, out_valid=0, result=0;
  - after rst drops, in_ready=1 and a fresh 1+2 yields 3.
